dircc_fanout_sequencer: RTL

DIRCC_FANOUT_SEQUENCER -- requirements
Module: dircc_fanout_sequencer

---
 rtl/dircc_fanout_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dircc_fanout_sequencer.sv
// Fans one send request out to every configured target of a (device, port), one packet per cycle.
// Latency: first packet one cycle after request acceptance; completion pulse one cycle after the last packet.
// Backpressure: a stalled packet holds all of its fields; configuration writes are dropped (and flagged) unless the block is idle.
module dircc_fanout_sequencer #(
  parameter int DEVICE_COUNT = 2,
  parameter int PORT_COUNT   = 1,
  parameter int MAX_TARGETS  = 4,
  parameter int HW_W         = 16,
  parameter int SW_W         = 8,
  parameter int PORT_W       = 4,
  parameter int FLAG_W       = 4,
  parameter int PAYLOAD_W    = 32,
  localparam int ADDR_W = HW_W + SW_W + PORT_W + FLAG_W,
  localparam int DEV_W  = (DEVICE_COUNT > 1) ? $clog2(DEVICE_COUNT) : 1,
  localparam int PRT_W  = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1,
  localparam int IDX_W  = (MAX_TARGETS > 1) ? $clog2(MAX_TARGETS) : 1,
  localparam int CNT_W  = $clog2(MAX_TARGETS + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cfg_we_i,
  input  logic                 cfg_num_we_i,
  input  logic [DEV_W-1:0]     cfg_dev_i,
  input  logic [PRT_W-1:0]     cfg_port_i,
  input  logic [IDX_W-1:0]     cfg_idx_i,
  input  logic [ADDR_W-1:0]    cfg_addr_i,
  input  logic [CNT_W-1:0]     cfg_num_i,
  output logic                 cfg_reject_o,
  input  logic                 rts_valid_i,
  output logic                 rts_ready_o,
  input  logic [DEV_W-1:0]     rts_dev_i,
  input  logic [PRT_W-1:0]     rts_port_i,
  input  logic [PAYLOAD_W-1:0] rts_payload_i,
  output logic                 pkt_valid_o,
  input  logic                 pkt_ready_i,
  output logic [ADDR_W-1:0]    pkt_dst_o,
  output logic [DEV_W-1:0]     pkt_src_dev_o,
  output logic [PAYLOAD_W-1:0] pkt_payload_o,
  output logic                 pkt_last_o,
  output logic                 done_valid_o,
  output logic [DEV_W-1:0]     done_dev_o,
  output logic [PRT_W-1:0]     done_port_o,
  output logic                 done_err_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [DEV_W:0] DEV_LIM = (DEV_W + 1)'(DEVICE_COUNT);
  localparam logic [PRT_W:0] PRT_LIM = (PRT_W + 1)'(PORT_COUNT);
  localparam logic [IDX_W:0] IDX_LIM = (IDX_W + 1)'(MAX_TARGETS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TARGETS);

  state_t                 state_q, state_d;
  logic [DEV_W-1:0]       dev_q, dev_d;
  logic [PRT_W-1:0]       port_q, port_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   err_q, err_d;
  logic                   cfg_reject_q, cfg_reject_d;

  logic [ADDR_W-1:0]      tbl_q     [DEVICE_COUNT][PORT_COUNT][MAX_TARGETS];
  logic [CNT_W-1:0]       cnt_tbl_q [DEVICE_COUNT][PORT_COUNT];

  logic                   rts_ok, is_last;
  logic [CNT_W-1:0]       rts_cnt;
  logic                   cfg_open, cfg_loc_ok, cfg_idx_ok, ent_wr, num_wr;
  logic [CNT_W-1:0]       num_sat;

  // Configuration gating: the table only changes while idle and not accepting a request.
  always_comb begin
    cfg_open     = (state_q == IDLE) && !rts_valid_i;
    cfg_loc_ok   = ({1'b0, cfg_dev_i} < DEV_LIM) && ({1'b0, cfg_port_i} < PRT_LIM);
    cfg_idx_ok   = ({1'b0, cfg_idx_i} < IDX_LIM);
    ent_wr       = cfg_we_i && cfg_open && cfg_loc_ok && cfg_idx_ok;
    num_wr       = cfg_num_we_i && cfg_open && cfg_loc_ok;
    cfg_reject_d = (cfg_we_i && !ent_wr) || (cfg_num_we_i && !num_wr);
    num_sat      = (cfg_num_i > CNT_MAX) ? CNT_MAX : cfg_num_i;
  end

  always_comb begin
    rts_ok  = ({1'b0, rts_dev_i} < DEV_LIM) && ({1'b0, rts_port_i} < PRT_LIM);
    rts_cnt = rts_ok ? cnt_tbl_q[rts_dev_i][rts_port_i] : '0;
    is_last = (CNT_W'(idx_q) + CNT_W'(1)) == cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    dev_d        = dev_q;
    port_d       = port_q;
    payload_d    = payload_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    err_d        = err_q;
    rts_ready_o  = 1'b0;
    pkt_valid_o  = 1'b0;
    pkt_last_o   = 1'b0;
    done_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        rts_ready_o = 1'b1;
        if (rts_valid_i) begin
          dev_d     = rts_dev_i;
          port_d    = rts_port_i;
          payload_d = rts_payload_i;
          cnt_d     = rts_cnt;
          idx_d     = '0;
          err_d     = !rts_ok;
          state_d   = (rts_cnt != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        pkt_valid_o = 1'b1;
        pkt_last_o  = is_last;
        if (pkt_ready_i) begin
          if (is_last) state_d = DONE;
          else         idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        done_valid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Table is only indexed while sending, so a rejected out-of-range request never reads it.
  assign pkt_dst_o     = (state_q == SEND) ? tbl_q[dev_q][port_q][idx_q] : '0;
  assign pkt_src_dev_o = dev_q;
  assign pkt_payload_o = payload_q;
  assign done_dev_o    = dev_q;
  assign done_port_o   = port_q;
  assign done_err_o    = (state_q == DONE) && err_q;
  assign busy_o        = (state_q != IDLE);
  assign cfg_reject_o  = cfg_reject_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      dev_q        <= '0;
      port_q       <= '0;
      payload_q    <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      cfg_reject_q <= 1'b0;
      for (int d = 0; d < DEVICE_COUNT; d++) begin
        for (int p = 0; p < PORT_COUNT; p++) begin
          cnt_tbl_q[d][p] <= '0;
          for (int t = 0; t < MAX_TARGETS; t++) tbl_q[d][p][t] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      dev_q        <= dev_d;
      port_q       <= port_d;
      payload_q    <= payload_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      cfg_reject_q <= cfg_reject_d;
      if (ent_wr) tbl_q[cfg_dev_i][cfg_port_i][cfg_idx_i] <= cfg_addr_i;
      if (num_wr) cnt_tbl_q[cfg_dev_i][cfg_port_i] <= num_sat;
    end
  end

endmodule
